// File: rtl/fifo_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader_if
// Purpose  : Bundles the FIFO read-side pins and the downstream valid/ready
//            stream pins used by fifo_stream_reader.
// Signals  : fifo_empty, fifo_data   - from the FIFO
//            fifo_cs, fifo_rd_en     - to the FIFO
//            m_valid, m_data         - stream word towards the consumer
//            m_ready                 - consumer accepts the word
// Modports : master - the reader (drives FIFO controls and stream word)
//            slave  - the environment (FIFO plus consumer)
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_stream_reader_if #(
   parameter int DATA_WIDTH = 32
) ();

   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_cs;
   logic                  fifo_rd_en;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;

   modport master (
      input  fifo_empty, fifo_data, m_ready,
      output fifo_cs, fifo_rd_en, m_valid, m_data
   );

   modport slave (
      output fifo_empty, fifo_data, m_ready,
      input  fifo_cs, fifo_rd_en, m_valid, m_data
   );

endinterface
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Purpose  : Drains a synchronous FIFO with one-cycle registered read latency
//            and presents its words as a valid/ready stream. A 2-entry skid
//            buffer absorbs the read latency so one word per cycle is
//            sustained while the consumer is ready.
// Ports    : clk      - system clock, rising edge
//            rst_n    - asynchronous active-low reset
//            en       - 1 = new FIFO reads may be issued
//            bus      - FIFO read pins and stream pins (master modport)
//            idle     - nothing buffered and no read in flight
//            word_cnt - words delivered since reset (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  wire                   clk,
   input  wire                   rst_n,
   input  wire                   en,
   fifo_stream_reader_if.master  bus,
   output logic                  idle,
   output logic [CNT_WIDTH-1:0]  word_cnt
);

   // Skid buffer storage and bookkeeping
   logic [DATA_WIDTH-1:0] r_mem [2];
   logic                  r_head;
   logic                  r_tail;
   logic [1:0]            r_buf_cnt;
   logic                  r_inflight;
   logic [CNT_WIDTH-1:0]  r_word_cnt;

   logic                  w_valid;
   logic                  w_pop;
   logic                  w_rd_en;
   logic [1:0]            w_next_cnt;

   assign w_valid = (r_buf_cnt != 2'd0);
   assign w_pop   = w_valid & bus.m_ready;

   // Occupancy after this edge, counting the in-flight capture and any pop.
   // It is also the number of slots already committed, so a new read is only
   // allowed when at most one slot is committed; this keeps buf_cnt <= 2.
   // Two bits are enough: buf_cnt <= 2 and inflight <= 1 give at most 3.
   assign w_next_cnt = r_buf_cnt + {1'b0, r_inflight} - {1'b0, w_pop};

   // rst_n gates the request so it drops immediately on reset assertion.
   assign w_rd_en = rst_n & en & ~bus.fifo_empty & (w_next_cnt <= 2'd1);

   assign bus.fifo_rd_en = w_rd_en;
   assign bus.fifo_cs    = w_rd_en;
   assign bus.m_valid    = w_valid;
   assign bus.m_data     = r_mem[r_head];
   assign idle           = (r_buf_cnt == 2'd0) & ~r_inflight;
   assign word_cnt       = r_word_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0]   <= '0;
         r_mem[1]   <= '0;
         r_head     <= 1'b0;
         r_tail     <= 1'b0;
         r_buf_cnt  <= 2'd0;
         r_inflight <= 1'b0;
         r_word_cnt <= '0;
      end else begin
         r_inflight <= w_rd_en;
         r_buf_cnt  <= w_next_cnt;
         // The FIFO word for the previous read is on fifo_data this cycle.
         // The tail never aliases a held head entry because buf_cnt <= 2.
         if (r_inflight) begin
            r_mem[r_tail] <= bus.fifo_data;
            r_tail        <= ~r_tail;
         end
         if (w_pop) begin
            r_head     <= ~r_head;
            r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
         end
      end
   end

   // Occupancy must never exceed the two storage entries.
   property p_no_overflow;
      @(posedge clk) disable iff (!rst_n) (r_buf_cnt != 2'd3);
   endproperty
   a_no_overflow: assert property (p_no_overflow);

   // A read must never be requested while the FIFO reports empty.
   property p_no_empty_read;
      @(posedge clk) disable iff (!rst_n) !(w_rd_en && bus.fifo_empty);
   endproperty
   a_no_empty_read: assert property (p_no_empty_read);

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_reader
// Purpose  : Self-checking bench for fifo_stream_reader. A behavioural FIFO
//            feeds the reader; a count-based reference model (reads issued,
//            words captured, words delivered) predicts every output each
//            cycle, and a scoreboard of written words checks stream order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

   localparam int DW = 32;
   localparam int CW = 4;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          en    = 1'b0;
   logic          idle;
   logic [CW-1:0] word_cnt;

   fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

   fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .bus      (bus),
      .idle     (idle),
      .word_cnt (word_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // ---------------- behavioural FIFO ----------------
   logic [DW-1:0] fmem [0:4095];
   int            f_wr;
   int            f_rd;
   int            rd_seen;
   logic [DW-1:0] f_dout;
   logic          wr_req  = 1'b0;
   logic [DW-1:0] wr_data = '0;

   assign bus.fifo_empty = (f_wr == f_rd);
   assign bus.fifo_data  = f_dout;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_wr    <= 0;
         f_rd    <= 0;
         f_dout  <= '0;
         rd_seen <= 0;
      end else begin
         if (bus.fifo_cs && bus.fifo_rd_en && (f_wr != f_rd)) begin
            f_dout  <= fmem[f_rd];
            f_rd    <= f_rd + 1;
            rd_seen <= rd_seen + 1;
         end
         if (wr_req) begin
            fmem[f_wr] <= wr_data;
            f_wr       <= f_wr + 1;
         end
      end
   end

   // ---------------- reference model ----------------
   // issued   : reads accepted by the FIFO so far
   // captured : reads whose data has had its capture edge
   // deliv    : words accepted by the consumer
   int            mdl_issued;
   int            mdl_captured;
   int            mdl_deliv;
   logic          mdl_rd  = 1'b0;
   logic          mdl_pop = 1'b0;
   logic [DW-1:0] sb_mem [0:4095];
   int            sb_wr = 0;
   int            sb_rd = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data  = '0;

   logic exp_valid;
   logic exp_pop;
   logic exp_rd;
   assign exp_valid = (mdl_captured > mdl_deliv);
   assign exp_pop   = exp_valid && bus.m_ready;
   assign exp_rd    = rst_n && en && (f_wr != f_rd) &&
                      ((mdl_issued - mdl_deliv - (exp_pop ? 1 : 0)) <= 1);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdl_issued   <= 0;
         mdl_captured <= 0;
         mdl_deliv    <= 0;
      end else begin
         mdl_issued   <= mdl_issued + (mdl_rd ? 1 : 0);
         mdl_captured <= mdl_issued;
         mdl_deliv    <= mdl_deliv + (mdl_pop ? 1 : 0);
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_m_valid", bus.m_valid, 1'b0);
         check("rst_rd_en", bus.fifo_rd_en, 1'b0);
         check("rst_idle", idle, 1'b1);
         check("rst_word_cnt", word_cnt, '0);
         check("rst_m_data", bus.m_data, '0);
         mdl_rd     <= 1'b0;
         mdl_pop    <= 1'b0;
         sb_rd      <= 0;
         prev_stall <= 1'b0;
      end else begin
         check("m_valid", bus.m_valid, exp_valid);
         check("rd_en", bus.fifo_rd_en, exp_rd);
         check("cs", bus.fifo_cs, exp_rd);
         check("idle", idle, (mdl_issued == mdl_deliv));
         check("word_cnt", word_cnt, 64'(mdl_deliv % (1 << CW)));
         if (prev_stall)
            check("stall_data", bus.m_data, prev_data);
         if (exp_pop) begin
            check("m_data", bus.m_data, sb_mem[sb_rd]);
            sb_rd <= sb_rd + 1;
         end
         prev_stall <= bus.m_valid && !bus.m_ready;
         prev_data  <= bus.m_data;
         mdl_rd     <= exp_rd;
         mdl_pop    <= exp_pop;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d);
      wr_req        = 1'b1;
      wr_data       = d;
      sb_mem[sb_wr] = d;
      sb_wr++;
      tick();
      wr_req = 1'b0;
   endtask

   task automatic wait_drained(input int limit);
      for (int i = 0; i < limit && !(idle && bus.fifo_empty); i++)
         tick();
      check("drain_done", (idle && bus.fifo_empty), 1'b1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      int base;
      int written;
      bus.m_ready = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // 1) three words streamed back to back
      bus.m_ready = 1'b1;
      push(32'h11);
      push(32'h22);
      push(32'h33);
      en = 1'b1;
      wait_drained(20);
      check("t1_word_cnt", word_cnt, 4'd3);
      check("t1_idle", idle, 1'b1);

      // 2) consumer stalled with 8 words queued
      en = 1'b0;
      bus.m_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(32'h100 + i);
      base = rd_seen;
      en = 1'b1;
      repeat (12) tick();
      check("t2_reads_stalled", rd_seen - base, 2);
      check("t2_valid", bus.m_valid, 1'b1);
      check("t2_head", bus.m_data, 32'h100);
      bus.m_ready = 1'b1;
      repeat (8) tick();
      check("t2_no_gap_cnt", word_cnt, 4'd11);
      wait_drained(20);

      // 3) en dropped right after the first read edge
      en = 1'b0;
      for (int i = 0; i < 4; i++) push(32'h200 + i);
      en = 1'b1;
      tick();
      en = 1'b0;
      repeat (6) tick();
      check("t3_fifo_left", f_wr - f_rd, 3);
      check("t3_one_delivered", word_cnt, 4'd12);
      en = 1'b1;
      wait_drained(20);
      check("t3_all_delivered", word_cnt, 4'd15);

      // 4) randomized traffic, 1000 words (word_cnt wraps repeatedly)
      written = 0;
      for (int c = 0; c < 20000 && written < 1000; c++) begin
         bus.m_ready = 1'($urandom_range(0, 1));
         en          = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 1) == 1) begin
            written++;
            push($urandom);
         end else begin
            tick();
         end
      end
      en = 1'b1;
      bus.m_ready = 1'b1;
      wait_drained(3000);
      check("t4_word_cnt", word_cnt, 4'((15 + 1000) % 16));

      // 5) asynchronous reset with the buffer occupied
      bus.m_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(32'h300 + i);
      repeat (4) tick();
      check("t5_pre_valid", bus.m_valid, 1'b1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_valid", bus.m_valid, 1'b0);
      check("t5_rd_en", bus.fifo_rd_en, 1'b0);
      check("t5_idle", idle, 1'b1);
      check("t5_word_cnt", word_cnt, '0);
      sb_wr = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (8) tick();
      check("t5_no_stale", bus.m_valid, 1'b0);
      bus.m_ready = 1'b1;
      push(32'hA5A5_0001);
      push(32'hA5A5_0002);
      wait_drained(20);
      check("t5_after_cnt", word_cnt, 4'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
